// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the command handshake, the operand/result bus to the combinational
// operation units, the response handshake and the error flag/clear pair.
// master : the sequencer (drives cmd_ready, op_*, rsp_* results, flag_err)
// slave  : the environment (drives commands, unit results, rsp_ready, err_clr)
interface alu_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [WIDTH-1:0] op_in1;
  logic [WIDTH-1:0] op_in2;
  logic [1:0]       op_sel;
  logic             op_en;
  logic [WIDTH-1:0] op_out;
  logic             op_z;
  logic             op_cf;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_z;
  logic             rsp_cf;

  logic             flag_err;
  logic             err_clr;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  op_out, op_z, op_cf,
    input  rsp_ready, err_clr,
    output cmd_ready, op_in1, op_in2, op_sel, op_en,
    output rsp_valid, rsp_res, rsp_z, rsp_cf, flag_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output op_out, op_z, op_cf,
    output rsp_ready, err_clr,
    input  cmd_ready, op_in1, op_in2, op_sel, op_en,
    input  rsp_valid, rsp_res, rsp_z, rsp_cf, flag_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Initiator for the ALU operation units: accepts one command, drives the
// operands for SETTLE cycles, captures result/flags, returns them over a
// valid/ready response and keeps a sticky zero-flag consistency error.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_op_sequencer_if.master (command, unit bus, response, error)
// Parameters:
//   WIDTH  : operand/result width
//   SETTLE : cycles operands are driven before capture (1..15)
module alu_op_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_op_sequencer_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             capture;
  logic             op_out_zero;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  // Capture edge is the last DRIVE cycle; unit inputs are only looked at here.
  assign capture     = (state == DRIVE) && (cnt == 4'd0);
  assign op_out_zero = is_zero(bus.op_out);

  // Handshake/enable outputs decode straight from the state register.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.op_en     = (state == DRIVE);
  assign bus.rsp_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      bus.op_in1   <= '0;
      bus.op_in2   <= '0;
      bus.op_sel   <= 2'd0;
      bus.rsp_res  <= '0;
      bus.rsp_z    <= 1'b0;
      bus.rsp_cf   <= 1'b0;
      bus.flag_err <= 1'b0;
    end else begin
      // A mismatch on the capture edge takes priority over a clear.
      if (capture && (bus.op_z != op_out_zero)) begin
        bus.flag_err <= 1'b1;
      end else if (bus.err_clr) begin
        bus.flag_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.op_in1 <= bus.cmd_a;
            bus.op_in2 <= bus.cmd_b;
            bus.op_sel <= bus.cmd_op;
            cnt        <= SETTLE_M1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Zero flag is recomputed locally; the unit's OP_Z only feeds the check.
            bus.rsp_res <= bus.op_out;
            bus.rsp_cf  <= bus.op_cf;
            bus.rsp_z   <= op_out_zero;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  bit   err_exp1;
  bit   zbad1;
  bit   glitch3;
  int   waited;

  logic [3:0] u1_out;
  logic       u1_cf;
  logic [3:0] u3_out;
  logic       u3_cf;

  alu_op_sequencer_if #(.WIDTH(4)) b1 ();
  alu_op_sequencer_if #(.WIDTH(4)) b3 ();

  alu_op_sequencer #(.WIDTH(4), .SETTLE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  alu_op_sequencer #(.WIDTH(4), .SETTLE(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behaviour of the operation units: {carry, result}.
  function automatic logic [4:0] ref_alu(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    case (op)
      2'd0:    return {1'b0, a & b};
      2'd1:    return {1'b0, a | b};
      2'd2:    return {1'b0, a} + {1'b0, b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  // Unit stub for the SETTLE=1 instance; zbad1 injects a wrong zero flag.
  always_comb begin
    {u1_cf, u1_out} = ref_alu(b1.op_sel, b1.op_in1, b1.op_in2);
    b1.op_out = u1_out;
    b1.op_cf  = u1_cf;
    b1.op_z   = (u1_out == 4'd0) ^ zbad1;
  end

  // Unit stub for the SETTLE=3 instance; glitch3 corrupts OP_OUT early in DRIVE.
  always_comb begin
    {u3_cf, u3_out} = ref_alu(b3.op_sel, b3.op_in1, b3.op_in2);
    b3.op_out = glitch3 ? ~u3_out : u3_out;
    b3.op_cf  = u3_cf;
    b3.op_z   = (u3_out == 4'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     input bit zbad, input bit clr, input int hold, output int wait_cyc);
    logic [4:0] r;
    wait_cyc = 0;
    while (b1.cmd_ready !== 1'b1 && wait_cyc < 20) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("cmd_ready_idle", b1.cmd_ready, 1);
    b1.cmd_valid = 1'b1;
    b1.cmd_op    = op;
    b1.cmd_a     = a;
    b1.cmd_b     = b;
    zbad1        = zbad;
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0;
    b1.cmd_a     = 4'($urandom);
    b1.cmd_b     = 4'($urandom);
    b1.cmd_op    = 2'($urandom);
    chk("drive_op_en", b1.op_en, 1);
    chk("drive_cmd_ready", b1.cmd_ready, 0);
    chk("drive_rsp_valid", b1.rsp_valid, 0);
    chk("drive_in1", b1.op_in1, a);
    chk("drive_in2", b1.op_in2, b);
    chk("drive_sel", b1.op_sel, op);
    b1.err_clr = clr;
    @(posedge clk); #1;
    b1.err_clr = 1'b0;
    zbad1      = 1'b0;
    r = ref_alu(op, a, b);
    if (zbad) err_exp1 = 1'b1;
    else if (clr) err_exp1 = 1'b0;
    chk("rsp_valid", b1.rsp_valid, 1);
    chk("rsp_op_en", b1.op_en, 0);
    chk("rsp_cmd_ready", b1.cmd_ready, 0);
    chk("rsp_res", b1.rsp_res, r[3:0]);
    chk("rsp_z", b1.rsp_z, (r[3:0] == 4'd0));
    chk("rsp_cf", b1.rsp_cf, r[4]);
    chk("flag_err", b1.flag_err, err_exp1);
    for (int k = 0; k < hold; k++) begin
      b1.rsp_ready = 1'b0;
      b1.cmd_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_rsp_valid", b1.rsp_valid, 1);
      chk("bp_res", b1.rsp_res, r[3:0]);
      chk("bp_z", b1.rsp_z, (r[3:0] == 4'd0));
      chk("bp_cf", b1.rsp_cf, r[4]);
      chk("bp_cmd_ready", b1.cmd_ready, 0);
      chk("bp_in1_kept", b1.op_in1, a);
    end
    b1.cmd_valid = 1'b0;
    b1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b1.rsp_ready = 1'b0;
    chk("post_rsp_valid", b1.rsp_valid, 0);
    chk("post_cmd_ready", b1.cmd_ready, 1);
    chk("post_res_hold", b1.rsp_res, r[3:0]);
  endtask

  initial begin
    logic [4:0] r3;
    logic [3:0] a3;
    logic [3:0] b3v;
    n_assert = 0;
    n_fail   = 0;
    err_exp1 = 1'b0;
    zbad1    = 1'b0;
    glitch3  = 1'b0;
    rst_n    = 1'b0;
    b1.cmd_valid = 1'b0; b1.cmd_op = 2'd0; b1.cmd_a = 4'd0; b1.cmd_b = 4'd0;
    b1.rsp_ready = 1'b0; b1.err_clr = 1'b0;
    b3.cmd_valid = 1'b0; b3.cmd_op = 2'd0; b3.cmd_a = 4'd0; b3.cmd_b = 4'd0;
    b3.rsp_ready = 1'b0; b3.err_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in1", b1.op_in1, 0);
    chk("rst_en", b1.op_en, 0);
    chk("rst_rsp_valid", b1.rsp_valid, 0);
    chk("rst_flag_err", b1.flag_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", b1.cmd_ready, 1);

    // AND path, zero result, flag mismatch sequence
    txn(2'd0, 4'hC, 4'hA, 1'b0, 1'b0, 0, waited);
    txn(2'd0, 4'h5, 4'hA, 1'b0, 1'b0, 0, waited);
    txn(2'd0, 4'h5, 4'hA, 1'b1, 1'b0, 0, waited);
    txn(2'd2, 4'h9, 4'h8, 1'b0, 1'b0, 0, waited);
    b1.err_clr = 1'b1;
    @(posedge clk); #1;
    b1.err_clr = 1'b0;
    err_exp1   = 1'b0;
    chk("err_clr_idle", b1.flag_err, 0);
    txn(2'd0, 4'h3, 4'hC, 1'b1, 1'b1, 0, waited);

    // Backpressure, then the next command goes in right after the handshake
    txn(2'd1, 4'h6, 4'h3, 1'b0, 1'b0, 5, waited);
    txn(2'd2, 4'hF, 4'h1, 1'b0, 1'b0, 0, waited);
    chk("next_cmd_no_wait", waited, 0);

    // Randomized commands
    for (int i = 0; i < 12; i++) begin
      txn(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
          int'($urandom_range(0, 2)), waited);
    end

    // Settle length on the SETTLE=3 instance
    a3  = 4'($urandom);
    b3v = 4'($urandom);
    b3.cmd_valid = 1'b1; b3.cmd_op = 2'd2; b3.cmd_a = a3; b3.cmd_b = b3v;
    @(posedge clk); #1;
    b3.cmd_valid = 1'b0;
    glitch3      = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) glitch3 = 1'b0;
      chk("s3_op_en", b3.op_en, 1);
      chk("s3_rsp_valid_low", b3.rsp_valid, 0);
      @(posedge clk); #1;
    end
    r3 = ref_alu(2'd2, a3, b3v);
    chk("s3_rsp_valid", b3.rsp_valid, 1);
    chk("s3_op_en_off", b3.op_en, 0);
    chk("s3_res", b3.rsp_res, r3[3:0]);
    chk("s3_cf", b3.rsp_cf, r3[4]);
    chk("s3_z", b3.rsp_z, (r3[3:0] == 4'd0));
    chk("s3_flag_err", b3.flag_err, 0);
    b3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    b3.rsp_ready = 1'b0;
    chk("s3_cmd_ready", b3.cmd_ready, 1);

    // Reset in the middle of DRIVE, with a sticky error and result pending
    txn(2'd2, 4'h7, 4'h2, 1'b1, 1'b0, 0, waited);
    b1.cmd_valid = 1'b1; b1.cmd_op = 2'd1; b1.cmd_a = 4'hA; b1.cmd_b = 4'h5;
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    err_exp1 = 1'b0;
    chk("mid_rst_in1", b1.op_in1, 0);
    chk("mid_rst_in2", b1.op_in2, 0);
    chk("mid_rst_sel", b1.op_sel, 0);
    chk("mid_rst_en", b1.op_en, 0);
    chk("mid_rst_rsp_valid", b1.rsp_valid, 0);
    chk("mid_rst_res", b1.rsp_res, 0);
    chk("mid_rst_z", b1.rsp_z, 0);
    chk("mid_rst_cf", b1.rsp_cf, 0);
    chk("mid_rst_flag_err", b1.flag_err, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", b1.rsp_valid, 0);
      chk("post_rst_ready", b1.cmd_ready, 1);
    end
    txn(2'd2, 4'h4, 4'h4, 1'b0, 1'b0, 1, waited);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
